// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, synchronous flush and an
// optional first-word-fall-through read port.
// Status flags are decoded from the registered count only, so they never
// depend combinationally on wr_en/rd_en.
// -----------------------------------------------------------------------------
module sync_fifo_param #(
   parameter int DATA_W    = 8,
   parameter int DEPTH     = 16,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       wr_en,
   input  logic [DATA_W-1:0]          data_in,
   input  logic                       rd_en,
   output logic [DATA_W-1:0]          data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   // Storage and state
   logic [DATA_W-1:0] mem_r [DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CW-1:0]     count_r;
   logic              overflow_r;
   logic              underflow_r;

   // Decoded status and handshake terms
   logic              empty_s;
   logic              full_s;
   logic              rd_ok_s;
   logic              wr_ok_s;
   logic              wr_rej_s;
   logic              rd_rej_s;
   logic [DATA_W-1:0] head_s;

   // Status decode from the registered count and request acceptance
   always_comb begin
      empty_s  = (count_r == CW'(0));
      full_s   = (count_r == CW'(DEPTH));
      rd_ok_s  = rd_en & ~empty_s;
      // a read in the same cycle frees a slot, so a full FIFO can still accept
      wr_ok_s  = wr_en & (~full_s | rd_ok_s);
      wr_rej_s = wr_en & ~wr_ok_s;
      rd_rej_s = rd_en & ~rd_ok_s;
      head_s   = mem_r[rd_ptr_r];
   end

   // Memory write port; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (!rst && !flush && wr_ok_s) begin
         mem_r[wr_ptr_r] <= data_in;
      end
   end

   // Write pointer: advances on every accepted write, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= AW'(0);
      end else if (flush) begin
         wr_ptr_r <= AW'(0);
      end else if (wr_ok_s) begin
         wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
         wr_ptr_r <= wr_ptr_r;
      end
   end

   // Read pointer: advances on every accepted read, wraps naturally
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_r <= AW'(0);
      end else if (flush) begin
         rd_ptr_r <= AW'(0);
      end else if (rd_ok_s) begin
         rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
         rd_ptr_r <= rd_ptr_r;
      end
   end

   // Occupancy: +1 on write only, -1 on read only, otherwise unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= CW'(0);
      end else if (flush) begin
         count_r <= CW'(0);
      end else begin
         case ({wr_ok_s, rd_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Sticky error flags; flush discards requests without flagging them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else if (flush) begin
         overflow_r  <= 1'b0;
         underflow_r <= 1'b0;
      end else begin
         overflow_r  <= overflow_r  | wr_rej_s;
         underflow_r <= underflow_r | rd_rej_s;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented directly; zero while nothing is stored
         always_comb begin
            if (empty_s) begin
               data_out = DATA_W'(0);
            end else begin
               data_out = head_s;
            end
         end
      end else begin : g_std
         logic [DATA_W-1:0] dout_r;

         // Registered read: capture head on an accepted read, hold otherwise
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               dout_r <= DATA_W'(0);
            end else if (!flush && rd_ok_s) begin
               dout_r <= head_s;
            end else begin
               dout_r <= dout_r;
            end
         end

         // Drive the registered read data onto the port
         always_comb begin
            data_out = dout_r;
         end
      end
   endgenerate

   // Port outputs decoded from registered state
   always_comb begin
      count        = count_r;
      empty        = empty_s;
      full         = full_s;
      almost_full  = (count_r >= CW'(AF_THRESH));
      almost_empty = (count_r <= CW'(AE_THRESH));
      overflow     = overflow_r;
      underflow    = underflow_r;
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Two instances share one stimulus stream: a standard-read FIFO and an FWFT
// FIFO. A queue-based reference model tracks contents and sticky flags; the
// expected standard-mode read data is pushed into a scoreboard queue when a
// read is accepted and popped by a separate monitor process.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int CW    = 5;
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          wr_en;
   logic          rd_en;
   logic [DW-1:0] data_in;

   logic [DW-1:0] dout0, dout1;
   logic          full0, empty0, af0, ae0, ovf0, udf0;
   logic          full1, empty1, af1, ae1, ovf1, udf1;
   logic [CW-1:0] cnt0, cnt1;

   sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(dout0), .full(full0), .empty(empty0),
      .almost_full(af0), .almost_empty(ae0), .count(cnt0),
      .overflow(ovf0), .underflow(udf0));

   sync_fifo_param #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .data_in(data_in),
      .rd_en(rd_en), .data_out(dout1), .full(full1), .empty(empty1),
      .almost_full(af1), .almost_empty(ae1), .count(cnt1),
      .overflow(ovf1), .underflow(udf1));

   always #5 clk = ~clk;

   // reference model state
   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] last_rd;
   bit            m_ovf, m_udf;
   bit            mon_en = 1'b0;

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      mq.delete();
      exp_q.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      last_rd = '0;
   endfunction

   // one clock edge worth of FIFO rules, applied to the pre-edge inputs
   function automatic void model_step();
      bit rd_ok, wr_ok;
      if (rst) begin
         model_reset();
         return;
      end
      if (flush) begin
         mq.delete();
         m_ovf = 1'b0;
         m_udf = 1'b0;
         return;
      end
      rd_ok = rd_en && (mq.size() > 0);
      wr_ok = wr_en && ((mq.size() < DEPTH) || rd_ok);
      if (rd_ok) exp_q.push_back(mq.pop_front());
      if (wr_ok) mq.push_back(data_in);
      if (wr_en && !wr_ok) m_ovf = 1'b1;
      if (rd_en && !rd_ok) m_udf = 1'b1;
   endfunction

   task automatic chk_status();
      int n;
      logic [DW-1:0] head;
      n    = mq.size();
      head = (n > 0) ? mq[0] : '0;
      chk("count0", 32'(cnt0), 32'(n));
      chk("count1", 32'(cnt1), 32'(n));
      chk("empty0", 32'(empty0), 32'(n == 0));
      chk("full0",  32'(full0),  32'(n == DEPTH));
      chk("af0",    32'(af0),    32'(n >= AF));
      chk("ae0",    32'(ae0),    32'(n <= AE));
      chk("ovf0",   32'(ovf0),   32'(m_ovf));
      chk("udf0",   32'(udf0),   32'(m_udf));
      chk("empty1", 32'(empty1), 32'(n == 0));
      chk("full1",  32'(full1),  32'(n == DEPTH));
      chk("af1",    32'(af1),    32'(n >= AF));
      chk("ae1",    32'(ae1),    32'(n <= AE));
      chk("ovf1",   32'(ovf1),   32'(m_ovf));
      chk("udf1",   32'(udf1),   32'(m_udf));
      chk("fwft_data", 32'(dout1), 32'(head));
   endtask

   // monitor: one read result per accepted read, otherwise data_out must hold
   always @(negedge clk) begin
      if (mon_en) begin
         if (exp_q.size() > 0) begin
            last_rd = exp_q.pop_front();
            chk("rd_data", 32'(dout0), 32'(last_rd));
         end else begin
            chk("rd_hold", 32'(dout0), 32'(last_rd));
         end
         chk_status();
      end
   end

   task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
      wr_en   = w;
      data_in = d;
      rd_en   = r;
      flush   = f;
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
      wr_en = 1'b0;
      rd_en = 1'b0;
      flush = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
      model_reset();
      #2;
      chk("rst_count", 32'(cnt0), 32'd0);
      chk("rst_empty", 32'(empty0), 32'd1);
      chk("rst_ae",    32'(ae0), 32'd1);
      chk("rst_dout0", 32'(dout0), 32'd0);
      chk("rst_dout1", 32'(dout1), 32'd0);
      @(negedge clk); #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // basic write/read order
      for (int i = 1; i <= 5; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
      chk("basic_count", 32'(cnt0), 32'd5);
      chk("basic_ae",    32'(ae0), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0);
         chk("basic_rd", 32'(dout0), 32'(i));
      end
      chk("basic_empty", 32'(empty0), 32'd1);
      chk("basic_udf",   32'(udf0), 32'd0);

      // fill, overflow, drain across pointer wrap
      for (int i = 0; i < DEPTH; i++) begin
         cyc(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
         if (i == AF - 2) chk("af_below", 32'(af0), 32'd0);
         if (i == AF - 1) chk("af_at",    32'(af0), 32'd1);
      end
      chk("full_set", 32'(full0), 32'd1);
      cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("ovf_set",  32'(ovf0), 32'd1);
      chk("ovf_cnt",  32'(cnt0), 32'd16);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("wrap_last", 32'(dout0), 32'h8F);
      cyc(1'b0, '0, 1'b0, 1'b1);

      // simultaneous read/write while full
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
      cyc(1'b1, 8'h55, 1'b1, 1'b0);
      chk("fullrw_cnt", 32'(cnt0), 32'd16);
      chk("fullrw_ovf", 32'(ovf0), 32'd0);
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      chk("fullrw_last", 32'(dout0), 32'h55);

      // simultaneous read/write while empty, then flush beats write
      cyc(1'b1, 8'h3C, 1'b1, 1'b0);
      chk("emptyrw_cnt", 32'(cnt0), 32'd1);
      chk("emptyrw_udf", 32'(udf0), 32'd1);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("emptyrw_rd", 32'(dout0), 32'h3C);
      cyc(1'b1, 8'h99, 1'b0, 1'b1);
      chk("flush_cnt", 32'(cnt0), 32'd0);
      chk("flush_udf", 32'(udf0), 32'd0);
      chk("flush_hold", 32'(dout0), 32'h3C);

      // FWFT head visibility
      cyc(1'b1, 8'h11, 1'b0, 1'b0);
      chk("fwft_first", 32'(dout1), 32'h11);
      cyc(1'b1, 8'h22, 1'b0, 1'b0);
      chk("fwft_still", 32'(dout1), 32'h11);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("fwft_pop", 32'(dout1), 32'h22);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("fwft_empty", 32'(empty1), 32'd1);
      chk("fwft_zero",  32'(dout1), 32'd0);

      // asynchronous reset mid-cycle with 7 entries
      for (int i = 0; i < 7; i++) cyc(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
      chk("pre_rst_cnt", 32'(cnt0), 32'd7);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_cnt",   32'(cnt0), 32'd0);
      chk("arst_empty", 32'(empty0), 32'd1);
      chk("arst_ae",    32'(ae1), 32'd1);
      chk("arst_dout0", 32'(dout0), 32'd0);
      chk("arst_dout1", 32'(dout1), 32'd0);
      model_reset();
      @(negedge clk); #1;
      rst = 1'b0;
      cyc(1'b1, 8'hA5, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      chk("post_rst_rd", 32'(dout0), 32'hA5);

      // randomized traffic with shifting write/read bias
      for (int i = 0; i < 2000; i++) begin
         int wp;
         wp = ((i / 200) % 2 == 0) ? 70 : 30;
         cyc($urandom_range(99, 0) < wp, DW'($urandom),
             $urandom_range(99, 0) < (100 - wp), $urandom_range(63, 0) == 0);
      end

      @(negedge clk);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
